// File: rtl/program_loader_pkg.sv
// Shared constants for the UART program loader: command bytes and FSM encodings.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package program_loader_pkg;

    // Command bytes recognised in IDLE / RUN
    localparam logic [7:0] CMD_LOAD_I = 8'hA5;
    localparam logic [7:0] CMD_LOAD_D = 8'h5A;
    localparam logic [7:0] CMD_RUN    = 8'hC3;
    localparam logic [7:0] CMD_HALT   = 8'h3C;

    // Loader state encodings
    localparam logic [2:0] LDR_IDLE    = 3'd0;
    localparam logic [2:0] LDR_CNT_LO  = 3'd1;
    localparam logic [2:0] LDR_CNT_HI  = 3'd2;
    localparam logic [2:0] LDR_PAYLOAD = 3'd3;
    localparam logic [2:0] LDR_RUN     = 3'd4;

    function automatic logic is_load_cmd(input logic [7:0] b);
        return (b == CMD_LOAD_I) || (b == CMD_LOAD_D);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler with a 2-bit byte counter.
// Latency: combinational word output on the byte that completes a word (0 cycles).
// Backpressure: none; every qualified byte is consumed.
// Ports: clk/rst (sync active-high), i_clr drops a partial word, i_byte_vld/i_byte_dat in,
//        o_word_vld pulses with the 4th byte, o_word_dat = {b3,b2,b1,b0}.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte_dat,
    output logic        o_word_vld,
    output logic [31:0] o_word_dat
);

    // Older bytes drift toward the LSB, so after three bytes r_shift = {b2,b1,b0}
    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_byte_vld) begin
            r_shift <= {i_byte_dat, r_shift[23:8]};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    assign o_word_vld = i_byte_vld && !i_clr && (r_cnt == 2'd3);
    assign o_word_dat = {i_byte_dat, r_shift};

endmodule

// File: rtl/program_loader.sv
// Framed UART-byte loader for the instruction/data BRAMs plus core run control.
// Latency: BRAM write strobe one clock after the 4th payload byte of each word.
// Backpressure: none; accepts a byte every clock, aborts a frame after TIMEOUT_CYCLES idle clocks.
// Ports: clk/rst (sync active-high), rx_data/rx_valid byte strobe in; i_w_*/d_w_* BRAM write
//        ports; pc_stall/d_bram_init_done run control; busy/err/words_loaded status.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DEPTH_WORDS    = 1024,
    parameter int TIMEOUT_CYCLES = 100000
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [31:0]           i_w_dat,
    output logic                  i_w_enb,
    output logic [3:0]            i_w_byte_enb,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [31:0]           d_w_dat,
    output logic                  d_w_enb,
    output logic [3:0]            d_w_byte_enb,
    output logic                  d_bram_init_done,
    output logic                  pc_stall,
    output logic                  busy,
    output logic                  err,
    output logic [10:0]           words_loaded
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]            r_state;
    logic                  r_tgt_d;
    logic [15:0]           r_cnt;
    logic [10:0]           r_words;
    logic                  r_err;
    logic [TW-1:0]         r_idle;
    logic [ADDR_WIDTH-1:0] r_i_addr;
    logic [31:0]           r_i_dat;
    logic                  r_i_enb;
    logic [ADDR_WIDTH-1:0] r_d_addr;
    logic [31:0]           r_d_dat;
    logic                  r_d_enb;

    logic                  w_busy;
    logic                  w_timeout;
    logic                  w_asm_vld;
    logic                  w_word_vld;
    logic [31:0]           w_word_dat;
    logic [15:0]           w_count;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_busy    = (r_state == LDR_CNT_LO) || (r_state == LDR_CNT_HI) || (r_state == LDR_PAYLOAD);
    // A byte landing on the terminal count wins over the timeout
    assign w_timeout = w_busy && !rx_valid && (r_idle == TW'(TIMEOUT_CYCLES - 1));
    assign w_asm_vld = rx_valid && (r_state == LDR_PAYLOAD);
    assign w_count   = {rx_data, r_cnt[7:0]};
    // words_loaded doubles as the word index k of the word being written
    assign w_last    = ((16'(r_words) + 16'd1) == r_cnt);
    assign w_addr    = ADDR_WIDTH'({r_words, 2'b00});

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_timeout),
        .i_byte_vld (w_asm_vld),
        .i_byte_dat (rx_data),
        .o_word_vld (w_word_vld),
        .o_word_dat (w_word_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= LDR_IDLE;
            r_tgt_d  <= 1'b0;
            r_cnt    <= '0;
            r_words  <= '0;
            r_err    <= 1'b0;
            r_idle   <= '0;
            r_i_addr <= '0;
            r_i_dat  <= '0;
            r_i_enb  <= 1'b0;
            r_d_addr <= '0;
            r_d_dat  <= '0;
            r_d_enb  <= 1'b0;
        end else begin
            r_i_enb <= 1'b0;
            r_d_enb <= 1'b0;

            if (!w_busy || rx_valid) r_idle <= '0;
            else                     r_idle <= r_idle + TW'(1);

            if (w_timeout) begin
                r_state <= LDR_IDLE;
                r_err   <= 1'b1;
            end else if (rx_valid) begin
                case (r_state)
                    LDR_IDLE: begin
                        if (is_load_cmd(rx_data)) begin
                            r_state <= LDR_CNT_LO;
                            r_tgt_d <= (rx_data == CMD_LOAD_D);
                            r_words <= '0;
                            r_err   <= 1'b0;
                        end else if (rx_data == CMD_RUN) begin
                            r_state <= LDR_RUN;
                            r_err   <= 1'b0;
                        end else begin
                            r_err   <= 1'b1;
                        end
                    end
                    LDR_CNT_LO: begin
                        r_cnt[7:0] <= rx_data;
                        r_state    <= LDR_CNT_HI;
                    end
                    LDR_CNT_HI: begin
                        r_cnt <= w_count;
                        if (w_count == 16'd0) begin
                            r_state <= LDR_IDLE;
                        end else if (w_count > 16'(DEPTH_WORDS)) begin
                            r_state <= LDR_IDLE;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= LDR_PAYLOAD;
                        end
                    end
                    LDR_PAYLOAD: begin
                        if (w_word_vld) begin
                            if (r_tgt_d) begin
                                r_d_addr <= w_addr;
                                r_d_dat  <= w_word_dat;
                                r_d_enb  <= 1'b1;
                            end else begin
                                r_i_addr <= w_addr;
                                r_i_dat  <= w_word_dat;
                                r_i_enb  <= 1'b1;
                            end
                            r_words <= r_words + 11'd1;
                            if (w_last) r_state <= LDR_IDLE;
                        end
                    end
                    LDR_RUN: begin
                        if (rx_data == CMD_HALT) begin
                            r_state <= LDR_IDLE;
                            r_err   <= 1'b0;
                        end
                    end
                    default: r_state <= LDR_IDLE;
                endcase
            end
        end
    end

    assign i_w_addr         = r_i_addr;
    assign i_w_dat          = r_i_dat;
    assign i_w_enb          = r_i_enb;
    assign i_w_byte_enb     = {4{r_i_enb}};
    assign d_w_addr         = r_d_addr;
    assign d_w_dat          = r_d_dat;
    assign d_w_enb          = r_d_enb;
    assign d_w_byte_enb     = {4{r_d_enb}};
    assign d_bram_init_done = (r_state == LDR_RUN);
    assign pc_stall         = (r_state != LDR_RUN);
    assign busy             = w_busy;
    assign err              = r_err;
    assign words_loaded     = r_words;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a frame-level byte model predicts BRAM writes and status.
// Latency: n/a.
// Backpressure: n/a.
module tb_program_loader;

    localparam int AW    = 12;
    localparam int DEPTH = 1024;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [AW-1:0] i_w_addr, d_w_addr;
    logic [31:0]   i_w_dat, d_w_dat;
    logic          i_w_enb, d_w_enb;
    logic [3:0]    i_w_byte_enb, d_w_byte_enb;
    logic          d_bram_init_done, pc_stall, busy, err;
    logic [10:0]   words_loaded;

    program_loader #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb), .i_w_byte_enb(i_w_byte_enb),
        .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb), .d_w_byte_enb(d_w_byte_enb),
        .d_bram_init_done(d_bram_init_done), .pc_stall(pc_stall), .busy(busy), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic [31:0] dat;
        int          words;
    } wr_t;

    int  checks = 0;
    int  failures = 0;
    wr_t exp_q[$];
    int  last_i_addr = -1;

    // Reference model: the in-progress frame is simply the list of its bytes so far
    bit  m_run = 0;
    bit  m_err = 0;
    int  m_words = 0;
    int  m_frame[$];
    int  m_idle = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_byte(input int b);
        int  sz, n, k;
        wr_t w;
        if (m_frame.size() == 0) begin
            if (m_run) begin
                if (b == 8'h3C) begin m_run = 0; m_err = 0; end
            end else if (b == 8'hA5 || b == 8'h5A) begin
                m_frame.push_back(b); m_words = 0; m_err = 0;
            end else if (b == 8'hC3) begin
                m_run = 1; m_err = 0;
            end else begin
                m_err = 1;
            end
        end else begin
            m_frame.push_back(b);
            sz = m_frame.size();
            if (sz == 3) begin
                n = m_frame[1] + 256 * m_frame[2];
                if (n == 0) m_frame.delete();
                else if (n > DEPTH) begin m_err = 1; m_frame.delete(); end
            end else if ((sz - 3) % 4 == 0) begin
                n = m_frame[1] + 256 * m_frame[2];
                k = (sz - 3) / 4 - 1;
                w.is_d  = (m_frame[0] == 8'h5A);
                w.addr  = k * 4;
                w.dat   = m_frame[sz-4] + m_frame[sz-3] * 256 + m_frame[sz-2] * 65536
                          + m_frame[sz-1] * 16777216;
                m_words = k + 1;
                w.words = m_words;
                exp_q.push_back(w);
                if (k + 1 == n) m_frame.delete();
            end
        end
    endtask

    task automatic tick_idle();
        rx_valid = 1'b0;
        @(posedge clk);
        m_idle++;
        if (m_idle == TMO && m_frame.size() != 0) begin
            m_frame.delete();
            m_err = 1;
        end
        #1;
    endtask

    task automatic send(input int b);
        rx_valid = 1'b1;
        rx_data  = 8'(b);
        @(posedge clk);
        model_byte(b);
        m_idle = 0;
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_g(input int b);
        repeat ($urandom_range(0, 2)) tick_idle();
        send(b);
    endtask

    task automatic check_status(input string name);
        chk({name, "_err"}, err, m_err);
        chk({name, "_busy"}, busy, m_frame.size() != 0);
        chk({name, "_pc_stall"}, pc_stall, !m_run);
        chk({name, "_dinit"}, d_bram_init_done, m_run);
        chk({name, "_words"}, words_loaded, m_words);
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_i_addr"}, i_w_addr, 0);
        chk({name, "_i_dat"}, i_w_dat, 0);
        chk({name, "_i_enb"}, i_w_enb, 0);
        chk({name, "_i_be"}, i_w_byte_enb, 0);
        chk({name, "_d_addr"}, d_w_addr, 0);
        chk({name, "_d_dat"}, d_w_dat, 0);
        chk({name, "_d_enb"}, d_w_enb, 0);
        chk({name, "_d_be"}, d_w_byte_enb, 0);
        chk({name, "_pc_stall"}, pc_stall, 1);
        chk({name, "_dinit"}, d_bram_init_done, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_err"}, err, 0);
        chk({name, "_words"}, words_loaded, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        m_run = 0; m_err = 0; m_words = 0; m_frame.delete(); m_idle = 0;
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pops one expected write per observed strobe
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (i_w_enb && d_w_enb) chk("both_ports_strobed", 1, 0);
                if (i_w_enb || d_w_enb) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", d_w_enb ? d_w_addr : i_w_addr, 32'hFFFF_FFFF);
                    end else begin
                        w = exp_q.pop_front();
                        chk("wr_port_is_d", d_w_enb, w.is_d);
                        chk("wr_addr", d_w_enb ? d_w_addr : i_w_addr, w.addr);
                        chk("wr_dat", d_w_enb ? d_w_dat : i_w_dat, w.dat);
                        chk("wr_be", d_w_enb ? d_w_byte_enb : i_w_byte_enb, 4'hF);
                        chk("wr_idle_be", d_w_enb ? i_w_byte_enb : d_w_byte_enb, 4'h0);
                        chk("wr_words", words_loaded, w.words);
                    end
                    if (i_w_enb) last_i_addr = int'(i_w_addr);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        check_reset_vals("reset");
        rst = 1'b0;

        // Instruction load of two words
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h10); send(8'h00);
        send(8'h93); send(8'h00); send(8'h20); send(8'h00);
        tick_idle();
        check_status("iload");
        chk("iload_words_const", words_loaded, 2);

        // Data load then run, then halt
        send(8'h5A); send(8'h01); send(8'h00);
        send(8'h08); send(8'h00); send(8'h00); send(8'h00);
        send(8'hC3);
        check_status("run");
        chk("run_pc_stall_const", pc_stall, 0);
        send(8'h3C);
        chk("halt_pc_stall_const", pc_stall, 1);
        check_status("halt");

        // Oversized count, then zero count
        send(8'hA5); send(8'h01); send(8'h04);
        check_status("badcnt");
        chk("badcnt_err_const", err, 1);
        send(8'hA5); send(8'h00); send(8'h00);
        check_status("zerocnt");
        chk("zerocnt_err_const", err, 0);

        // Timeout with a partial word, then a byte landing on the terminal count
        send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
        repeat (TMO) tick_idle();
        check_status("timeout");
        chk("timeout_err_const", err, 1);
        send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
        repeat (TMO - 1) tick_idle();
        send(8'h33); send(8'h44);
        tick_idle();
        check_status("tmo_edge");
        chk("tmo_edge_words_const", words_loaded, 1);

        // Reset after 5 of 8 payload bytes; the rest are then commands
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h10); send(8'h00); send(8'h93);
        do_reset();
        check_reset_vals("midrst");
        send(8'h00); send(8'h20); send(8'h00);
        check_status("after_rst");

        // Back-to-back 1024-word load
        send(8'hA5); send(8'h00); send(8'h04);
        for (int i = 0; i < 4 * DEPTH; i++) send($urandom_range(0, 255));
        tick_idle();
        check_status("full");
        chk("full_words_const", words_loaded, 1024);
        chk("full_last_addr", last_i_addr, 32'hFFC);

        // Randomized mix of frames, commands, timeouts and resets
        for (int it = 0; it < 80; it++) begin
            int r, n;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: begin
                    n = $urandom_range(0, 5);
                    send_g((r % 2 == 0) ? 8'hA5 : 8'h5A);
                    send_g(n % 256); send_g(n / 256);
                    for (int j = 0; j < 4 * n; j++) send_g($urandom_range(0, 255));
                end
                4: begin
                    n = $urandom_range(DEPTH + 1, 65535);
                    send_g(8'h5A); send_g(n % 256); send_g(n / 256);
                end
                5: begin
                    send_g(8'hA5); send_g(8'h03); send_g(8'h00);
                    repeat ($urandom_range(0, 6)) send_g($urandom_range(0, 255));
                    repeat (TMO + $urandom_range(0, 3)) tick_idle();
                end
                6: send_g(8'hC3);
                7: send_g(8'h3C);
                8: send_g($urandom_range(0, 255));
                default: do_reset();
            endcase
            tick_idle();
            check_status("rnd");
        end

        repeat (3) tick_idle();
        chk("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
